// File: rtl/rv32_mod_bus_arbiter.sv
// Two-port bus arbiter: LSU (port 0, priority) and fetch (port 1) share one
// external bus. Each port holds one pending request; port 1 is protected from
// starvation and a stuck bus is aborted after TIMEOUT cycles.
module rv32_mod_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_do,
  output logic        m0_busy,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_di,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_do,
  output logic        m1_busy,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_di,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_do,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_di
);

  // Counters keep at least one bit so TIMEOUT=0 / MAX_CONSEC=0 still elaborate.
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned SW = (MAX_CONSEC > 0) ? $clog2(MAX_CONSEC + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  localparam logic [SW-1:0] STV_LIM = SW'(MAX_CONSEC);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e r_state, w_state_d;

  logic [1:0]       r_pv, r_pwr;
  logic [1:0][3:0]  r_pbe;
  logic [1:0][31:0] r_paddr, r_pdo;
  logic             r_gnt;
  logic [SW-1:0]    r_stv;
  logic [TW-1:0]    r_tmo;
  logic             r_bus_req, r_bus_wr;
  logic [3:0]       r_bus_be;
  logic [31:0]      r_bus_addr, r_bus_do;

  logic [1:0]       w_req, w_wr, w_busy;
  logic [1:0][3:0]  w_be;
  logic [1:0][31:0] w_addr, w_do;
  logic             w_grant, w_sel, w_tmo, w_ok, w_fail, w_done;

  assign w_req  = {m1_req, m0_req};
  assign w_wr   = {m1_wr, m0_wr};
  assign w_be   = {m1_be, m0_be};
  assign w_addr = {m1_addr, m0_addr};
  assign w_do   = {m1_do, m0_do};

  assign bus_req  = r_bus_req;
  assign bus_wr   = r_bus_wr;
  assign bus_be   = r_bus_be;
  assign bus_addr = r_bus_addr;
  assign bus_do   = r_bus_do;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Arbitration choice, completion decode and next state
  always_comb begin
    w_state_d = r_state;
    w_grant   = 1'b0;
    w_tmo     = 1'b0;
    w_ok      = 1'b0;
    w_fail    = 1'b0;
    w_done    = 1'b0;
    // Port 1 wins only when port 0 is absent or has used up its run of grants.
    w_sel     = r_pv[1] && (!r_pv[0] || (r_stv == STV_LIM));
    case (r_state)
      StIdle: begin
        if (|r_pv) begin
          w_grant   = 1'b1;
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        w_tmo  = (TIMEOUT != 0) && (r_tmo == TMO_LIM);
        // err dominates ack; a real ack in the timeout cycle still counts.
        w_ok   = bus_ack && !bus_err;
        w_fail = bus_err || (w_tmo && !bus_ack);
        w_done = w_ok || w_fail;
        if (w_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Port-facing completion and busy outputs
  always_comb begin
    m0_ack    = w_ok && !r_gnt;
    m1_ack    = w_ok && r_gnt;
    m0_err    = w_fail && !r_gnt;
    m1_err    = w_fail && r_gnt;
    m0_di     = m0_ack ? bus_di : 32'h0;
    m1_di     = m1_ack ? bus_di : 32'h0;
    // Busy drops in the completion cycle so a port can re-request back to back.
    w_busy[0] = r_pv[0] && !(w_done && !r_gnt);
    w_busy[1] = r_pv[1] && !(w_done && r_gnt);
    m0_busy   = w_busy[0];
    m1_busy   = w_busy[1];
  end

  // Per-port pending request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv    <= '0;
      r_pwr   <= '0;
      r_pbe   <= '0;
      r_paddr <= '0;
      r_pdo   <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_done && (r_gnt == 1'(n))) r_pv[n] <= 1'b0;
        if (w_req[n] && !w_busy[n]) begin
          r_pv[n]    <= 1'b1;
          r_pwr[n]   <= w_wr[n];
          r_pbe[n]   <= w_be[n];
          r_paddr[n] <= w_addr[n];
          r_pdo[n]   <= w_do[n];
        end
      end
    end
  end

  // Bus-side registers, timeout counter and starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_req  <= 1'b0;
      r_bus_wr   <= 1'b0;
      r_bus_be   <= '0;
      r_bus_addr <= '0;
      r_bus_do   <= '0;
      r_gnt      <= 1'b0;
      r_tmo      <= '0;
      r_stv      <= '0;
    end else begin
      r_bus_req <= w_grant;
      if (w_grant) begin
        r_gnt      <= w_sel;
        r_bus_wr   <= r_pwr[w_sel];
        r_bus_be   <= r_pbe[w_sel];
        r_bus_addr <= r_paddr[w_sel];
        r_bus_do   <= r_pdo[w_sel];
        r_tmo      <= '0;
      end else if (w_done) begin
        r_bus_wr   <= 1'b0;
        r_bus_be   <= '0;
        r_bus_addr <= '0;
        r_bus_do   <= '0;
      end else if ((r_state == StBusy) && (r_tmo != TMO_LIM)) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (!r_pv[1]) begin
        r_stv <= '0;
      end else if (w_grant) begin
        if (w_sel)                 r_stv <= '0;
        else if (r_stv != STV_LIM) r_stv <= r_stv + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Scoreboard bench for rv32_mod_bus_arbiter: expected bus grants and port
// completions are queued as requests are driven and checked by a monitor.
module tb_rv32_mod_bus_arbiter;

  localparam int RNONE = 0, RACK = 1, RERR = 2, RBOTH = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] dout;
  } gnt_t;

  typedef struct packed {
    logic        port;
    logic [1:0]  kind;  // {ack, err}
    logic [31:0] di;
    logic [7:0]  dly;   // cycles from bus_req to completion
  } cpl_t;

  logic        clk, reset;
  logic        m0_req, m0_wr, m0_busy, m0_ack, m0_err;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_do, m0_di;
  logic        m1_req, m1_wr, m1_busy, m1_ack, m1_err;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_do, m1_di;
  logic        bus_req, bus_wr, bus_ack, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_do, bus_di;

  gnt_t exp_gnt[$];
  cpl_t exp_cpl[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc = 0;
  int   resp_mode = RACK, resp_dly = 1;
  logic resp_busy;
  logic idle_bad = 1'b0;

  rv32_mod_bus_arbiter #(.TIMEOUT(8), .MAX_CONSEC(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_be(m0_be), .m0_addr(m0_addr), .m0_do(m0_do),
    .m0_busy(m0_busy), .m0_ack(m0_ack), .m0_err(m0_err), .m0_di(m0_di),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_be(m1_be), .m1_addr(m1_addr), .m1_do(m1_do),
    .m1_busy(m1_busy), .m1_ack(m1_ack), .m1_err(m1_err), .m1_di(m1_di),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_do(bus_do), .bus_ack(bus_ack), .bus_err(bus_err), .bus_di(bus_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    return a ^ 32'hDEAD_BFEF;
  endfunction

  function automatic gnt_t mk(input logic [31:0] a, input logic wr, input logic [3:0] be,
                              input logic [31:0] d);
    gnt_t g;
    g.addr = a; g.wr = wr; g.be = be; g.dout = d;
    return g;
  endfunction

  function automatic cpl_t mkc(input logic p, input logic [1:0] k, input logic [31:0] di,
                               input logic [7:0] dly);
    cpl_t c;
    c.port = p; c.kind = k; c.di = di; c.dly = dly;
    return c;
  endfunction

  // Bus responder: answers each bus_req after resp_dly cycles as resp_mode says.
  initial begin
    logic [31:0] ra;
    bus_ack = 1'b0; bus_err = 1'b0; bus_di = '0; resp_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus_req && !reset) begin
        resp_busy = 1'b1;
        ra = bus_addr;
        if (resp_mode != RNONE) begin
          for (int k = 0; k < resp_dly; k++) begin @(posedge clk); #1; end
          bus_ack = (resp_mode == RACK) || (resp_mode == RBOTH);
          bus_err = (resp_mode == RERR) || (resp_mode == RBOTH);
          bus_di  = resp_data(ra);
          @(posedge clk); #1;
          bus_ack = 1'b0; bus_err = 1'b0; bus_di = '0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expected grants on bus_req and expected completions on ack/err.
  initial begin
    gnt_t cur, obs;
    cpl_t e;
    logic in_txn, hold_bad;
    int   gnt_cyc, last_cpl;
    in_txn = 1'b0; hold_bad = 1'b0; gnt_cyc = 0; last_cpl = -10; cur = '0;
    forever begin
      @(negedge clk);
      obs = {bus_addr, bus_wr, bus_be, bus_do};
      if (reset) begin
        in_txn = 1'b0;
      end else begin
        if (!in_txn && !bus_req && (obs != '0)) idle_bad = 1'b1;
        if (bus_req) begin
          if (exp_gnt.size() == 0) begin
            check("gnt_unexpected", obs, '0);
          end else begin
            cur = exp_gnt.pop_front();
            check("gnt_fields", obs, cur);
          end
          check("gnt_gap", 160'(cyc - last_cpl >= 2), 160'(1));
          gnt_cyc = cyc; in_txn = 1'b1; hold_bad = 1'b0;
        end
        if (in_txn && (obs != cur)) hold_bad = 1'b1;
        if (m0_ack || m0_err || m1_ack || m1_err) begin
          if (exp_cpl.size() == 0) begin
            check("cpl_unexpected", {m0_ack, m0_err, m1_ack, m1_err}, '0);
          end else begin
            e = exp_cpl.pop_front();
            check("cpl_flags", {m0_ack, m0_err, m1_ack, m1_err},
                  e.port ? {2'b00, e.kind} : {e.kind, 2'b00});
            check("cpl_di", {m0_di, m1_di}, e.port ? {32'h0, e.di} : {e.di, 32'h0});
            check("cpl_latency", 160'(cyc - gnt_cyc), 160'(e.dly));
            check("bus_hold", hold_bad, 1'b0);
          end
          in_txn = 1'b0; last_cpl = cyc;
        end
      end
    end
  end

  task automatic req(input logic p0, input gnt_t g0, input logic p1, input gnt_t g1);
    @(posedge clk); #1;
    m0_req = p0; m0_wr = g0.wr; m0_be = g0.be; m0_addr = g0.addr; m0_do = g0.dout;
    m1_req = p1; m1_wr = g1.wr; m1_be = g1.be; m1_addr = g1.addr; m1_do = g1.dout;
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_gnt.size() != 0 || exp_cpl.size() != 0 || resp_busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 160'(n < 100), 160'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] out_vec();
    return 160'({m0_busy, m0_ack, m0_err, m0_di, m1_busy, m1_ack, m1_err, m1_di,
                 bus_req, bus_wr, bus_be, bus_addr, bus_do});
  endfunction

  initial begin
    gnt_t g, z, a0[5];
    int   n;
    logic dropped;
    z = '0;
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_be = 0; m0_addr = 0; m0_do = 0;
    m1_req = 0; m1_wr = 0; m1_be = 0; m1_addr = 0; m1_do = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read on port 1, ack two cycles after bus_req.
    resp_mode = RACK; resp_dly = 2;
    g = mk(32'h100, 1'b0, 4'hF, 32'h0);
    exp_gnt.push_back(g);
    exp_cpl.push_back(mkc(1'b1, 2'b10, 32'hDEADBEEF, 8'd2));
    req(1'b0, z, 1'b1, g);
    @(negedge clk); check("latency_n1", bus_req, 1'b0);
    @(negedge clk); check("latency_n2", bus_req, 1'b1);
    drain("single_drain");
    check("single_busy_low", m1_busy, 1'b0);

    // Write on port 0.
    resp_dly = 1;
    g = mk(32'h40, 1'b1, 4'h3, 32'h1234_5678);
    exp_gnt.push_back(g);
    exp_cpl.push_back(mkc(1'b0, 2'b10, resp_data(32'h40), 8'd1));
    req(1'b1, g, 1'b0, z);
    drain("write_drain");

    // Contention: port 0 first, port 1 follows without re-requesting.
    resp_dly = 3;
    a0[0] = mk(32'h80, 1'b0, 4'hF, 32'h0);
    g     = mk(32'h84, 1'b1, 4'hC, 32'h0000_CAFE);
    exp_gnt.push_back(a0[0]); exp_gnt.push_back(g);
    exp_cpl.push_back(mkc(1'b0, 2'b10, resp_data(32'h80), 8'd3));
    exp_cpl.push_back(mkc(1'b1, 2'b10, resp_data(32'h84), 8'd3));
    req(1'b1, a0[0], 1'b1, g);
    dropped = 1'b0; n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (m1_ack) break;
      if (!m1_busy) dropped = 1'b1;
      n++;
    end
    check("contend_m1_served", 160'(n < 60), 160'(1));
    check("contend_m1_busy_held", dropped, 1'b0);
    drain("contend_drain");

    // Starvation: port 1 waits while port 0 re-requests in every ack cycle.
    resp_dly = 1;
    for (int k = 0; k < 5; k++) a0[k] = mk(32'h200 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
    g = mk(32'h300, 1'b0, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) exp_gnt.push_back(a0[k]);
    exp_gnt.push_back(g); exp_gnt.push_back(a0[4]);
    for (int k = 0; k < 4; k++) exp_cpl.push_back(mkc(1'b0, 2'b10, resp_data(a0[k].addr), 8'd1));
    exp_cpl.push_back(mkc(1'b1, 2'b10, resp_data(32'h300), 8'd1));
    exp_cpl.push_back(mkc(1'b0, 2'b10, resp_data(a0[4].addr), 8'd1));
    req(1'b1, a0[0], 1'b1, g);
    for (int k = 1; k < 5; k++) begin
      n = 0;
      do begin
        @(posedge clk); #2;
        n++;
      end while (!m0_ack && n < 40);
      check("starve_ack_seen", 160'(n < 40), 160'(1));
      m0_req = 1'b1; m0_wr = 1'b0; m0_be = 4'hF; m0_addr = a0[k].addr; m0_do = 32'h0;
      @(posedge clk); #1;
      m0_req = 1'b0;
    end
    drain("starve_drain");

    // Timeout: ack arrives only after the abort and must be ignored.
    resp_mode = RACK; resp_dly = 12;
    g = mk(32'h400, 1'b0, 4'hF, 32'h0);
    exp_gnt.push_back(g);
    exp_cpl.push_back(mkc(1'b0, 2'b01, 32'h0, 8'd8));
    req(1'b1, g, 1'b0, z);
    drain("timeout_drain");
    check("timeout_busy_low", m0_busy, 1'b0);

    // Simultaneous ack and err in the bus_req cycle.
    resp_mode = RBOTH; resp_dly = 0;
    g = mk(32'h500, 1'b0, 4'hF, 32'h0);
    exp_gnt.push_back(g);
    exp_cpl.push_back(mkc(1'b1, 2'b01, 32'h0, 8'd0));
    req(1'b0, z, 1'b1, g);
    drain("both_drain");

    // Reset mid-transaction; the later ack must not reach any port.
    resp_mode = RACK; resp_dly = 6;
    g = mk(32'h600, 1'b1, 4'hF, 32'h5555_AAAA);
    exp_gnt.push_back(g);
    req(1'b1, g, 1'b0, z);
    n = 0;
    while (exp_gnt.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check("reset_txn_started", 160'(n < 40), 160'(1));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_mid_outputs", out_vec(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    drain("reset_drain");
    check("reset_busy_low", m0_busy, 1'b0);

    // Normal service after the aborted transaction.
    resp_mode = RACK; resp_dly = 1;
    g = mk(32'h700, 1'b0, 4'h1, 32'h0);
    exp_gnt.push_back(g);
    exp_cpl.push_back(mkc(1'b0, 2'b10, resp_data(32'h700), 8'd1));
    req(1'b1, g, 1'b0, z);
    drain("post_reset_drain");

    check("idle_bus_zero", idle_bad, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rv32_mod_bus_arbiter.md
RV32_MOD_BUS_ARBITER -- requirements
Module: rv32_mod_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles allowed without ack/err before the arbiter aborts; 0 disables the timeout.
REQ-002 SHALL have parameter MAX_CONSEC, default 4: number of consecutive port-0 grants allowed while port 1 is pending.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mN_req  input  1  one-cycle request pulse from requester N, N=0 (LSU, priority) and N=1 (fetch).
REQ-006 mN_wr / mN_be / mN_addr / mN_do  input  1/4/32/32  write flag, byte enables, word address, write data; sampled only in the mN_req cycle.
REQ-007 mN_busy  output  1  combinational; high while port N has a request pending or in flight.
REQ-008 mN_ack / mN_err  output  1/1  completion pulses for port N.
REQ-009 mN_di  output  32  read data for port N; equals bus_di during mN_ack, else 0.
REQ-010 bus_req  output  1  one-cycle request pulse to the external bus.
REQ-011 bus_wr / bus_be / bus_addr / bus_do  output  1/4/32/32  registered, held from bus_req until completion.
REQ-012 bus_ack / bus_err  input  1/1  completion from the external bus.
REQ-013 bus_di  input  32  read data, valid with bus_ack.

Function
REQ-014 Each port SHALL hold a pending register (valid, wr, be, addr, do), loaded on mN_req when mN_busy is low.
REQ-015 An mN_req while mN_busy is high SHALL be ignored, with no state change.
REQ-016 FSM states SHALL be IDLE and BUSY.
REQ-017 In IDLE with at least one pending valid, the arbiter SHALL select a port, register that port's fields onto bus_* and pulse bus_req for one cycle, then enter BUSY.
REQ-018 Latency: mN_req in cycle N SHALL give bus_req in cycle N+2 when the arbiter is idle and uncontended.
REQ-019 Selection SHALL be fixed priority, port 0 over port 1, subject to the starvation rule below.
REQ-020 Starvation counter: SHALL increment on each port-0 grant made while port 1 is pending.
REQ-021 When the starvation counter equals MAX_CONSEC and port 1 is pending, port 1 SHALL be selected.
REQ-022 The starvation counter SHALL clear on any port-1 grant and whenever port 1 is not pending.
REQ-023 BUSY SHALL accept bus_ack/bus_err in any cycle, including the first cycle after bus_req.
REQ-024 On completion, the granted port's mN_ack/mN_err SHALL pulse in the same cycle, combinationally.
REQ-025 On completion, that port's pending valid SHALL clear, and the FSM SHALL return to IDLE on the next edge.
REQ-026 With bus_ack and bus_err both high, only mN_err SHALL pulse and mN_di SHALL be 0.
REQ-027 bus_* address, data, wr and be SHALL hold stable throughout BUSY, and SHALL return to 0 in IDLE.
REQ-028 Timeout: a cycle counter SHALL clear on entry to BUSY.
REQ-029 If TIMEOUT>0 and the timeout counter reaches TIMEOUT without completion, the granted port's mN_err SHALL pulse, its pending SHALL clear, and the FSM SHALL go to IDLE.
REQ-030 The timeout counter width SHALL be $clog2(TIMEOUT+1), and it SHALL not wrap.
REQ-031 bus_ack/bus_err in IDLE (late or spurious) SHALL be ignored and SHALL not reach any port.
REQ-032 A new grant SHALL occur no earlier than the cycle after a return to IDLE, leaving at least one idle cycle between bus transactions.
REQ-033 The non-granted port SHALL keep its pending request unchanged and its mN_ack/mN_err low.

Reset
REQ-034 On reset, the FSM SHALL go to IDLE.
REQ-035 On reset, pending valids, the starvation counter and the timeout counter SHALL clear.
REQ-036 On reset, all outputs SHALL go to 0, including bus_req, bus_*, mN_ack, mN_err, mN_di and mN_busy.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction silently: no mN_ack or mN_err SHALL be issued, and a subsequent bus_ack SHALL be ignored.

Verification
REQ-038 Single read: m1_req with addr 0x100, bus_ack two cycles after bus_req, bus_di 0xDEADBEEF -> bus_req in cycle +2 with bus_addr 0x100; m1_ack with m1_di 0xDEADBEEF; m1_busy low afterwards.
REQ-039 Contention: m0_req and m1_req in the same cycle -> port 0 served first, then port 1 without a new m1_req; m1_busy stays high throughout.
REQ-040 Starvation: port 1 pending and port 0 re-requesting on every ack, MAX_CONSEC=4 -> exactly 4 port-0 grants, then a port-1 grant.
REQ-041 Timeout: TIMEOUT=8 and no bus_ack -> m0_err pulses 8 cycles after BUSY entry; a bus_ack afterwards produces no mN_ack.
REQ-042 Simultaneous bus_ack and bus_err -> only mN_err pulses, and mN_di is 0.
REQ-043 Reset during BUSY, then bus_ack -> all outputs 0, no mN_ack, and a subsequent m0_req is served normally.
